// File: rtl/display_scheduler_if.sv
// Requester/display bundle for display_scheduler: running time, setting UI,
// transient message and the four registered digit outputs.
interface display_scheduler_if;
    logic [15:0] time_digits;
    logic        set_req;
    logic [15:0] set_digits;
    logic [1:0]  set_cursor;
    logic        msg_req;
    logic [15:0] msg_digits;
    logic        msg_ack;
    logic [3:0]  out0;
    logic [3:0]  out1;
    logic [3:0]  out2;
    logic [3:0]  out3;
    logic [1:0]  owner;
    logic        blink_phase;

    modport master (
        output time_digits, set_req, set_digits, set_cursor, msg_req, msg_digits,
        input  msg_ack, out0, out1, out2, out3, owner, blink_phase
    );

    modport slave (
        input  time_digits, set_req, set_digits, set_cursor, msg_req, msg_digits,
        output msg_ack, out0, out1, out2, out3, owner, blink_phase
    );
endinterface

// File: rtl/display_scheduler.sv
// Fixed-priority owner of the 4-digit display (msg > set > time) with message
// hold timer and cursor blink; every output comes straight from a flop.
module display_scheduler #(
    parameter int unsigned BLINK_HALF  = 500000,
    parameter int unsigned HOLD_CYCLES = 3000000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    display_scheduler_if.slave   bus
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam int unsigned BW = $clog2(BLINK_HALF);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    // Encoding doubles as the owner code, so owner is the state flop itself.
    typedef enum logic [1:0] {
        ST_TIME = 2'b00,
        ST_SET  = 2'b01,
        ST_MSG  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        msg_q, msg_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic               ack_q, ack_d;
    logic [1:0]         cursor_q, cursor_d;
    logic [3:0][3:0]    out_q, out_d;
    logic [15:0]        src;

    always_comb begin
        msg_d = msg_q;
        if (bus.msg_req) begin
            msg_d = bus.msg_digits;
        end
        ack_d    = bus.msg_req;
        cursor_d = bus.set_cursor;

        state_d = state_q;
        if (bus.msg_req) begin
            state_d = ST_MSG;
        end else begin
            unique case (state_q)
                ST_TIME: state_d = bus.set_req ? ST_SET : ST_TIME;
                ST_SET:  state_d = bus.set_req ? ST_SET : ST_TIME;
                ST_MSG: begin
                    if (hold_q == '0) begin
                        state_d = bus.set_req ? ST_SET : ST_TIME;
                    end
                end
                default: state_d = ST_TIME;
            endcase
        end

        hold_d = '0;
        if (bus.msg_req) begin
            hold_d = HOLD_LOAD;
        end else if (state_q == ST_MSG && hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end

        // Blink restarts high on SET entry and on any cursor move.
        blink_cnt_d = '0;
        blink_d     = 1'b1;
        if (state_d == ST_SET && state_q == ST_SET && bus.set_cursor == cursor_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_d     = blink_q;
            end
        end

        unique case (state_d)
            ST_SET:  src = bus.set_digits;
            ST_MSG:  src = msg_d;
            default: src = bus.time_digits;
        endcase

        for (int unsigned i = 0; i < 4; i++) begin
            out_d[i] = src[4*(3-i) +: 4];
            if (state_d == ST_SET && !blink_d && bus.set_cursor == 2'(i)) begin
                out_d[i] = 4'hF;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_TIME;
            msg_q       <= '0;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
            ack_q       <= 1'b0;
            cursor_q    <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            ack_q       <= ack_d;
            cursor_q    <= cursor_d;
            out_q       <= out_d;
        end
    end

    assign bus.msg_ack     = ack_q;
    assign bus.owner       = state_q;
    assign bus.blink_phase = blink_q;
    assign bus.out0        = out_q[0];
    assign bus.out1        = out_q[1];
    assign bus.out2        = out_q[2];
    assign bus.out3        = out_q[3];

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with BLINK_HALF=4, HOLD_CYCLES=10.
module tb_display_scheduler;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    display_scheduler_if bus ();

    display_scheduler #(
        .BLINK_HALF  (4),
        .HOLD_CYCLES (10)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.out0, bus.out1, bus.out2, bus.out3};
    endfunction

    logic [15:0] blink_exp [9] = '{16'h0930, 16'h0930, 16'h0930, 16'h0930,
                                   16'h09F0, 16'h09F0, 16'h09F0, 16'h09F0, 16'h0930};
    logic        phase_exp [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held with busy inputs
        reset_n         = 1'b0;
        bus.time_digits = 16'hABCD;
        bus.set_req     = 1'b1;
        bus.set_digits  = 16'h5678;
        bus.set_cursor  = 2'd3;
        bus.msg_req     = 1'b1;
        bus.msg_digits  = 16'h5555;
        tick();
        tick();
        chk("rst_out", outs(), 16'h0000);
        chk("rst_owner", 16'(bus.owner), 16'h0);
        chk("rst_blink", 16'(bus.blink_phase), 16'h1);
        chk("rst_ack", 16'(bus.msg_ack), 16'h0);

        bus.set_req     = 1'b0;
        bus.msg_req     = 1'b0;
        bus.time_digits = 16'h1234;
        reset_n         = 1'b1;
        tick();
        chk("time_out", outs(), 16'h1234);
        chk("time_owner", 16'(bus.owner), 16'h0);

        // Set blink on cursor 2
        bus.set_req    = 1'b1;
        bus.set_digits = 16'h0930;
        bus.set_cursor = 2'd2;
        for (int c = 0; c < 9; c++) begin
            tick();
            chk("set_owner", 16'(bus.owner), 16'h1);
            chk("set_blink_out", outs(), blink_exp[c]);
            chk("set_blink_phase", 16'(bus.blink_phase), 16'(phase_exp[c]));
        end
        tick();
        tick();
        tick();
        tick();
        chk("set_low_again", outs(), 16'h09F0);

        // Cursor move restarts the blink high
        bus.set_cursor = 2'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("cur_out", outs(), 16'h0930);
            chk("cur_phase", 16'(bus.blink_phase), 16'h1);
        end
        tick();
        chk("cur_blank", outs(), 16'hF930);

        // Message over time
        bus.set_req = 1'b0;
        tick();
        chk("back_time", 16'(bus.owner), 16'h0);
        bus.msg_req    = 1'b1;
        bus.msg_digits = 16'hFFFF;
        tick();
        bus.msg_req = 1'b0;
        chk("msg_ack", 16'(bus.msg_ack), 16'h1);
        chk("msg_owner", 16'(bus.owner), 16'h2);
        chk("msg_out", outs(), 16'hFFFF);
        tick();
        chk("msg_ack_drop", 16'(bus.msg_ack), 16'h0);
        chk("msg_hold2", 16'(bus.owner), 16'h2);
        for (int c = 3; c <= 10; c++) begin
            tick();
            chk("msg_hold", 16'(bus.owner), 16'h2);
        end
        tick();
        chk("msg_end_owner", 16'(bus.owner), 16'h0);
        chk("msg_end_out", outs(), 16'h1234);

        // Message restart, then return to SET
        bus.set_req    = 1'b1;
        bus.set_cursor = 2'd1;
        tick();
        tick();
        tick();
        chk("rs_set", 16'(bus.owner), 16'h1);
        bus.msg_req    = 1'b1;
        bus.msg_digits = 16'h0E11;
        tick();
        bus.msg_req = 1'b0;
        chk("rs_msg1", outs(), 16'h0E11);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("rs_hold1", 16'(bus.owner), 16'h2);
        end
        bus.msg_req    = 1'b1;
        bus.msg_digits = 16'h0E22;
        tick();
        bus.msg_req = 1'b0;
        chk("rs_ack2", 16'(bus.msg_ack), 16'h1);
        chk("rs_msg2", outs(), 16'h0E22);
        for (int c = 2; c <= 10; c++) begin
            tick();
            chk("rs_hold2", 16'(bus.owner), 16'h2);
        end
        tick();
        chk("rs_owner", 16'(bus.owner), 16'h1);
        chk("rs_phase", 16'(bus.blink_phase), 16'h1);
        chk("rs_out", outs(), 16'h0930);

        // Simultaneous requests
        bus.set_req = 1'b0;
        tick();
        chk("sim_time", 16'(bus.owner), 16'h0);
        bus.set_req    = 1'b1;
        bus.msg_req    = 1'b1;
        bus.msg_digits = 16'hC0DE;
        tick();
        bus.msg_req = 1'b0;
        chk("sim_msg", 16'(bus.owner), 16'h2);
        for (int c = 2; c <= 10; c++) begin
            tick();
            chk("sim_hold", 16'(bus.owner), 16'h2);
        end
        tick();
        chk("sim_set", 16'(bus.owner), 16'h1);
        chk("sim_phase", 16'(bus.blink_phase), 16'h1);
        bus.set_req = 1'b0;
        tick();
        chk("sim_time2", 16'(bus.owner), 16'h0);

        bus.set_req = 1'b1;
        bus.msg_req = 1'b1;
        tick();
        bus.msg_req = 1'b0;
        chk("drop_msg", 16'(bus.owner), 16'h2);
        tick();
        bus.set_req = 1'b0;
        for (int c = 3; c <= 10; c++) begin
            tick();
            chk("drop_hold", 16'(bus.owner), 16'h2);
        end
        tick();
        chk("drop_time", 16'(bus.owner), 16'h0);

        // Reset mid-MSG at hold count 5
        bus.msg_req    = 1'b1;
        bus.msg_digits = 16'h7777;
        tick();
        bus.msg_req = 1'b0;
        chk("rm_msg", outs(), 16'h7777);
        tick();
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #2;
        chk("rm_async_out", outs(), 16'h0000);
        chk("rm_async_owner", 16'(bus.owner), 16'h0);
        chk("rm_async_blink", 16'(bus.blink_phase), 16'h1);
        reset_n = 1'b1;
        tick();
        chk("rm_owner", 16'(bus.owner), 16'h0);
        chk("rm_ack", 16'(bus.msg_ack), 16'h0);
        chk("rm_out", outs(), 16'h1234);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("rm_no_msg", 16'(bus.owner), 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
